// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined WIDTH-bit logic unit with a valid/ready stream,
// a result accumulator, and zero/parity/popcount flags on the output stage.

module logic_unit_lane (
  input  logic [2:0] op,
  input  logic       a,
  input  logic       x,
  output logic       r
);
  always_comb begin
    r = 1'b0;
    case (op)
      3'b000: r = a & x;
      3'b001: r = a | x;
      3'b010: r = a ^ x;
      3'b011: r = ~(a & x);
      3'b100: r = ~(a | x);
      3'b101: r = ~(a ^ x);
      3'b110: r = ~a;
      3'b111: r = a;
      default: r = 1'b0;
    endcase
  end
endmodule

module logic_unit_pipe #(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             acc_en,
  input  logic             acc_init,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             parity,
  output logic [CW-1:0]    popcnt
);
  localparam int STAGES = 2;

  logic [STAGES:1]  vld_pipe;
  logic [WIDTH-1:0] acc, x, r_new, s1_r, s2_r;
  logic             s2_ready, accept;
  logic             s2_zero, s2_parity;
  logic [CW-1:0]    s1_cnt, s2_cnt;

  assign s2_ready = !vld_pipe[2] || out_ready;
  assign in_ready = !vld_pipe[1] || s2_ready;
  assign accept   = in_valid && in_ready;

  // Accumulator feeds back only when accumulating without a seed.
  assign x = (acc_en && !acc_init) ? acc : b;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    logic_unit_lane u_lane (.op(op), .a(a[i]), .x(x[i]), .r(r_new[i]));
  end

  always_comb begin
    s1_cnt = '0;
    for (int i = 0; i < WIDTH; i++) s1_cnt = s1_cnt + CW'(s1_r[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe  <= '0;
      acc       <= '0;
      s1_r      <= '0;
      s2_r      <= '0;
      s2_zero   <= 1'b1;
      s2_parity <= 1'b0;
      s2_cnt    <= '0;
    end else begin
      if (accept) s1_r <= r_new;
      if (accept && acc_en) acc <= r_new;
      // in_ready means stage 1 is empty or emptying, so its next valid is just the accept.
      if (in_ready) vld_pipe[1] <= accept;
      if (s2_ready) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1]) begin
          s2_r      <= s1_r;
          s2_zero   <= (s1_r == '0);
          s2_parity <= ^s1_r;
          s2_cnt    <= s1_cnt;
        end
      end
    end
  end

  assign out_valid = vld_pipe[2];
  assign result    = s2_r;
  assign zero      = s2_zero;
  assign parity    = s2_parity;
  assign popcnt    = s2_cnt;
endmodule

// File: tb/tb_logic_unit_pipe.sv
// Bench for logic_unit_pipe: directed scenarios plus random traffic, checked
// against a queue-based model of in-flight beats and the accumulator.

module tb_logic_unit_pipe;
  logic       clk, rst;
  logic       in_valid, in_ready, acc_en, acc_init, out_valid, out_ready;
  logic [2:0] op;
  logic [7:0] a, b, result;
  logic       zero, parity;
  logic [3:0] popcnt;

  logic        v32, rdy32, ov32, z32, p32;
  logic [31:0] a32, b32, r32;
  logic [5:0]  c32;
  logic        v1, rdy1, ov1, z1, p1, a1, b1, r1, c1;

  int n_cmp = 0;
  int n_bad = 0;

  logic_unit_pipe #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .acc_en(acc_en), .acc_init(acc_init), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero), .parity(parity), .popcnt(popcnt));

  logic_unit_pipe #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(v32), .in_ready(rdy32), .op(3'b010),
    .a(a32), .b(b32), .acc_en(1'b0), .acc_init(1'b0), .out_valid(ov32),
    .out_ready(1'b1), .result(r32), .zero(z32), .parity(p32), .popcnt(c32));

  logic_unit_pipe #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(rdy1), .op(3'b010),
    .a(a1), .b(b1), .acc_en(1'b0), .acc_init(1'b0), .out_valid(ov1),
    .out_ready(1'b1), .result(r1), .zero(z1), .parity(p1), .popcnt(c1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: in-flight beats in order; vis marks a beat already on the outputs.
  typedef struct packed { logic [7:0] r; logic vis; } ent_t;
  ent_t       q[$];
  logic [7:0] acc_m = 8'h00;
  logic       last_acc;

  function automatic logic [7:0] ref_op(logic [2:0] o, logic [7:0] x1, logic [7:0] x2);
    case (o)
      3'd0: return x1 & x2;
      3'd1: return x1 | x2;
      3'd2: return x1 ^ x2;
      3'd3: return ~(x1 & x2);
      3'd4: return ~(x1 | x2);
      3'd5: return ~(x1 ^ x2);
      3'd6: return ~x1;
      default: return x1;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at negedge, check model vs DUT, advance model, pass the edge.
  task automatic step(input logic v, input logic [2:0] o, input logic [7:0] aa,
                      input logic [7:0] bb, input logic ae, input logic ai,
                      input logic ordy, input logic r = 1'b0, input logic ce = 1'b0,
                      input logic [7:0] ce_v = 8'h00, input logic rc = 1'b0);
    logic       exp_rdy, exp_ov;
    logic [7:0] xr, rr;
    ent_t       e;
    @(negedge clk);
    in_valid = v; op = o; a = aa; b = bb; acc_en = ae; acc_init = ai;
    out_ready = ordy; rst = r;
    #1;
    exp_rdy = (q.size() < 2) || ordy;
    exp_ov  = (q.size() > 0) && q[0].vis;
    chk("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
    chk("out_valid", {31'b0, out_valid}, {31'b0, exp_ov});
    if (exp_ov) begin
      chk("result", {24'b0, result}, {24'b0, q[0].r});
      chk("zero", {31'b0, zero}, {31'b0, q[0].r == 8'h00});
      chk("parity", {31'b0, parity}, $countones(q[0].r) % 2);
      chk("popcnt", {28'b0, popcnt}, $countones(q[0].r));
    end
    if (ce) begin
      chk("dir_valid", {31'b0, out_valid}, 32'd1);
      chk("dir_result", {24'b0, result}, {24'b0, ce_v});
    end
    if (rc) begin
      chk("rst_result", {24'b0, result}, 32'd0);
      chk("rst_zero", {31'b0, zero}, 32'd1);
      chk("rst_parity", {31'b0, parity}, 32'd0);
      chk("rst_popcnt", {28'b0, popcnt}, 32'd0);
    end
    last_acc = v && exp_rdy && !r;
    if (r) begin
      q.delete();
      acc_m = 8'h00;
    end else begin
      if (exp_ov && ordy) void'(q.pop_front());
      if (q.size() > 0 && !q[0].vis) begin
        e = q[0]; e.vis = 1'b1; q[0] = e;
      end
      if (last_acc) begin
        xr = (ae && !ai) ? acc_m : bb;
        rr = ref_op(o, aa, xr);
        q.push_back({rr, 1'b0});
        if (ae) acc_m = rr;
      end
    end
    @(posedge clk);
  endtask

  initial begin
    int idx, guard;
    logic [7:0] bp [4];
    rst = 1'b1; in_valid = 0; op = 0; a = 0; b = 0; acc_en = 0; acc_init = 0; out_ready = 1;
    v32 = 0; a32 = 0; b32 = 0; v1 = 0; a1 = 0; b1 = 0;
    repeat (2) @(posedge clk);

    // OR example, reset state checked on the first cycle after reset
    step(1, 3'd1, 8'h09, 8'h05, 0, 0, 1, 0, 0, 8'h00, 1);
    step(1, 3'd1, 8'h03, 8'h0C, 0, 0, 1);
    step(0, 3'd0, 8'h00, 8'h00, 0, 0, 1, 0, 1, 8'h0D);
    step(0, 3'd0, 8'h00, 8'h00, 0, 0, 1, 0, 1, 8'h0F);

    // All eight ops on 0xA5 / 0x0F, one result per cycle after the fill
    begin
      logic [7:0] tbl [8];
      tbl = '{8'h05, 8'hAF, 8'hAA, 8'hFA, 8'h50, 8'h55, 8'h5A, 8'hA5};
      for (int i = 0; i < 10; i++)
        step(i < 8, 3'(i), 8'hA5, 8'h0F, 0, 0, 1, 0, i >= 2, tbl[(i >= 2) ? i - 2 : 0]);
    end

    // Accumulate OR chain; the acc_en=0 beat must not disturb acc
    step(1, 3'd1, 8'h01, 8'h00, 1, 1, 1);
    step(1, 3'd1, 8'h02, 8'h55, 1, 0, 1);
    step(1, 3'd1, 8'h04, 8'h55, 1, 0, 1, 0, 1, 8'h01);
    step(1, 3'd1, 8'h80, 8'h55, 1, 0, 1, 0, 1, 8'h03);
    step(1, 3'd1, 8'hF0, 8'h0F, 0, 1, 1, 0, 1, 8'h07);
    step(1, 3'd1, 8'h00, 8'h00, 1, 0, 1, 0, 1, 8'h87);
    step(0, 3'd0, 8'h00, 8'h00, 0, 0, 1, 0, 1, 8'hFF);
    step(0, 3'd0, 8'h00, 8'h00, 0, 0, 1, 0, 1, 8'h87);

    // Backpressure: hold each beat until accepted, release out_ready later
    bp = '{8'h11, 8'h22, 8'h33, 8'h44};
    idx = 0; guard = 0;
    while ((idx < 4 || q.size() > 0) && guard < 30) begin
      step(idx < 4, 3'd7, bp[(idx < 4) ? idx : 3], 8'h00, 0, 0, guard >= 5);
      if (last_acc) idx++;
      guard++;
    end
    if (guard >= 30) begin n_cmp++; n_bad++; $error("FAIL bp_timeout: got %0d want 4", idx); end

    // Fill both stages, then reset mid-stream
    guard = 0;
    while (q.size() < 2 && guard < 6) begin
      step(1, 3'd2, 8'h3C, 8'h0F, 0, 0, 0);
      guard++;
    end
    chk("fill_depth", q.size(), 32'd2);
    step(1, 3'd1, 8'hFF, 8'h00, 1, 1, 0, 1);
    step(1, 3'd1, 8'h10, 8'h00, 1, 0, 1, 0, 0, 8'h00, 1);
    step(0, 3'd0, 8'h00, 8'h00, 0, 0, 1);
    step(0, 3'd0, 8'h00, 8'h00, 0, 0, 1, 0, 1, 8'h10);

    // Random traffic with occasional resets
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, 3'($urandom), 8'($urandom), 8'($urandom),
           1'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0,
           $urandom_range(0, 60) == 0);
    step(0, 3'd0, 8'h00, 8'h00, 0, 0, 1);
    step(0, 3'd0, 8'h00, 8'h00, 0, 0, 1);

    // WIDTH=32 and WIDTH=1 builds: XOR of all-ones with zero
    @(negedge clk);
    v32 = 1; a32 = 32'hFFFF_FFFF; b32 = 32'h0; v1 = 1; a1 = 1; b1 = 0;
    @(posedge clk);
    @(negedge clk);
    v32 = 0; v1 = 0;
    @(posedge clk);
    @(negedge clk);
    chk("w32_valid", {31'b0, ov32}, 32'd1);
    chk("w32_result", r32, 32'hFFFF_FFFF);
    chk("w32_popcnt", {26'b0, c32}, 32'd32);
    chk("w32_parity", {31'b0, p32}, 32'd0);
    chk("w32_zero", {31'b0, z32}, 32'd0);
    chk("w1_result", {31'b0, r1}, 32'd1);
    chk("w1_popcnt", {31'b0, c1}, 32'd1);
    chk("w1_parity", {31'b0, p1}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/logic_unit_pipe.md
# logic_unit_pipe

Parametrised, two-stage pipelined bitwise logic unit that generalises the 4-bit OR test block to WIDTH bits and eight selectable operations. It adds a valid/ready streaming interface, an internal accumulator for reducing a stream of operands, and result flags (zero, parity, popcount). It sits in the BinaryLogic step as the execution unit for logical ops, fed by the operand/decode stage and drained by writeback.

## Interface
- WIDTH, 8, operand/result width in bits (≥1)
- CW, $clog2(WIDTH+1), popcount width (derived localparam, not overridable)

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  unit can accept a beat this cycle
- op  in  3  operation select (below)
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- acc_en  in  1  use/update accumulator on this beat
- acc_init  in  1  with acc_en: take B instead of accumulator (seed)
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts output
- result  out  WIDTH  operation result
- zero  out  1  result == 0
- parity  out  1  XOR-reduce of result
- popcnt  out  CW  number of 1 bits in result

## Operation
- Ops: 000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR, 110 NOT A (B ignored), 111 PASS A (B ignored).
- Second operand X: acc_en=0 → X=b; acc_en=1, acc_init=1 → X=b; acc_en=1, acc_init=0 → X=acc.
- Beat accepted when in_valid && in_ready. On acceptance, stage 1 registers R = A op X. If acc_en=1, acc <= R in the same edge. acc_en=0 leaves acc unchanged. acc_init ignored when acc_en=0.
- Stage 2 registers R plus zero/parity/popcnt computed from stage-1 R.
- Accumulator updates at stage-1 acceptance, so back-to-back accumulate beats use the previous beat's result with no bubble or hazard.
- Stall rules: s2_ready = !s2_valid || out_ready; in_ready = !s1_valid || s2_ready. Stage 1 advances to stage 2 when s1_valid && s2_ready. A stalled stage holds its data and flags unchanged.
- Backpressure never drops or duplicates beats. in_valid and operands are not sampled when in_ready=0. Acc does not change on non-accepted beats.
- All arithmetic is bitwise, WIDTH bits, no carries. popcnt is in 0..WIDTH.

## Timing
- Reset (synchronous, rst high at a rising edge): s1_valid=0, s2_valid=0, out_valid=0, result=0, zero=1, parity=0, popcnt=0, acc=0.
- in_ready is 1 in the first cycle after reset is released.
- Reset mid-stream discards all in-flight beats and clears acc. An accepted input coincident with rst is dropped.
- Latency is 2 cycles: a beat accepted at edge N appears on outputs (out_valid=1) after edge N+1, valid through edge N+2 if out_ready=1.
- Throughput is 1 beat/cycle with out_ready held high.
- Full pipeline with out_ready=0: s1 and s2 are both full and in_ready=0. When out_ready rises, in_ready rises in the same cycle (combinational path), so accept and drain happen on the same edge.
- Simultaneous accept into s1 and s1→s2 transfer: both occur on the same edge.
- out_valid stays high with stable result/flags until out_ready=1.

## Test plan
- WIDTH=4, op=OR, a=1001, b=0101, out_ready=1 → two cycles later result=1101, zero=0, parity=1, popcnt=3. Then a=0011, b=1100 → result=1111, popcnt=4, parity=0.
- Sweep all 8 ops with WIDTH=8, a=0xA5, b=0x0F → AND 0x05, OR 0xAF, XOR 0xAA, NAND 0xFA, NOR 0x50, XNOR 0x55, NOT 0x5A, PASS 0xA5. Each appears in order, one per cycle, after a 2-cycle fill.
- Accumulate with WIDTH=8, op=OR: beat 1 (acc_init=1, a=0x01, b=0x00) gives 0x01. Then a=0x02, 0x04, 0x80 back-to-back (acc_init=0) give 0x03, 0x07, 0x87. A following beat with acc_en=0, a=0xF0, b=0x0F gives 0xFF and leaves acc at 0x87.
- Backpressure: stream 4 beats with out_ready=0 → in_ready drops after 2 accepted, out_valid=1 holding beat 1. Raise out_ready → all 4 beats emerge in order, no loss or duplication.
- Reset mid-stream: assert rst with both stages full and acc=0x87 → next cycle out_valid=0, result=0, zero=1, in_ready=1. A subsequent accumulate beat with acc_init=0, op=OR, a=0x10 gives 0x10.
- WIDTH=1 and WIDTH=32 builds: XOR of 0xFFFFFFFF and 0x0 gives 0xFFFFFFFF, popcnt=32, parity=0.
